// File: rtl/adc_frame_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adc_frame_pkg: shared constants for adc_frame_packer. Build option:        |
// | FRAME_CHECKSUM_EN (adds an XOR trailer word).          Revision: 1.0       |
// +----------------------------------------------------------------------------+
package adc_frame_pkg;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hA5A5_5A5A;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR0    = 3'd1;
  localparam logic [2:0] ST_HDR1    = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_TRAIL   = 3'd4;
  localparam logic [2:0] ST_DROP    = 3'd5;

  localparam int HDR_SEQ_LSB  = 16;
  localparam int HDR_DROP_LSB = 0;

  function automatic int frame_words(input int payload_words);
`ifdef FRAME_CHECKSUM_EN
    return payload_words + 3;
`else
    return payload_words + 2;
`endif
  endfunction

  function automatic logic [31:0] make_header(input logic [15:0] seq,
                                              input logic [15:0] drops);
    logic [31:0] hdr;
    hdr = 32'd0;
    hdr[HDR_SEQ_LSB +: 16]  = seq;
    hdr[HDR_DROP_LSB +: 16] = drops;
    return hdr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_frame_packer_pair.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sample_pair_packer: joins two 16-bit samples into one 32-bit word, first   |
// | sample in the high half.                               Revision: 1.0       |
// +----------------------------------------------------------------------------+
module sample_pair_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        load,
  input  logic [15:0] sample_data,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [15:0] hi_half;
  logic        hi_full;

  // start discards any half word left over and takes the frame's first sample
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_half    <= 16'd0;
      hi_full    <= 1'b0;
      word_valid <= 1'b0;
      word_data  <= 32'd0;
    end else begin
      word_valid <= 1'b0;
      if (start) begin
        hi_half <= sample_data;
        hi_full <= 1'b1;
      end else if (load) begin
        if (hi_full) begin
          word_data  <= {hi_half, sample_data};
          word_valid <= 1'b1;
          hi_full    <= 1'b0;
        end else begin
          hi_half <= sample_data;
          hi_full <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_frame_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adc_frame_packer: frames packed ADC words into the DDR input FIFO, whole   |
// | frames admitted or dropped. Option: FRAME_CHECKSUM_EN. Revision: 1.0       |
// +----------------------------------------------------------------------------+
module adc_frame_packer
  import adc_frame_pkg::*;
#(
  parameter int          PAYLOAD_WORDS = 256,
  parameter int          FIFO_DEPTH    = 1024,
  parameter logic [31:0] SYNC_WORD     = SYNC_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  output logic        fifo_we,
  output logic [31:0] fifo_data,
  input  logic [9:0]  fifo_count,
  input  logic        fifo_full,
  output logic [31:0] frame_seq,
  output logic [15:0] drop_count,
  output logic        overflow
);

  localparam int FRAME_WORDS = frame_words(PAYLOAD_WORDS);
  localparam int ADMIT_LIMIT = FIFO_DEPTH - FRAME_WORDS - 2;
  localparam int WCW         = (PAYLOAD_WORDS > 2) ? $clog2(PAYLOAD_WORDS) : 1;
  localparam int DCW         = $clog2(2 * PAYLOAD_WORDS);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(PAYLOAD_WORDS - 1);
  localparam logic [DCW-1:0] DROP_LAST = DCW'(2 * PAYLOAD_WORDS - 1);

  logic [2:0]     state;
  logic [2:0]     state_next;
  logic [WCW-1:0] word_cnt;
  logic [DCW-1:0] drop_seen;
  logic           admit;
  logic           start_req;
  logic           frame_start;
  logic           enter_drop;
  logic           frame_done;
  logic           wr_req;
  logic [31:0]    wr_data;
  logic           pack_load;
  logic           word_valid;
  logic [31:0]    word_data;
`ifdef FRAME_CHECKSUM_EN
  logic [31:0]    checksum;
`endif

  always_comb begin
    admit      = $signed({22'd0, fifo_count}) <= ADMIT_LIMIT;
    start_req  = sample_valid && enable;
    state_next = state;
    enter_drop = 1'b0;
    frame_done = 1'b0;
    wr_req     = 1'b0;
    wr_data    = 32'd0;
    case (state)
      ST_IDLE: begin
        if (start_req) begin
          state_next = admit ? ST_HDR0 : ST_DROP;
          enter_drop = !admit;
        end
      end
      ST_HDR0: begin
        wr_req     = 1'b1;
        wr_data    = SYNC_WORD;
        state_next = ST_HDR1;
      end
      ST_HDR1: begin
        wr_req     = 1'b1;
        wr_data    = make_header(frame_seq[15:0], drop_count);
        state_next = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (word_valid) begin
          wr_req  = 1'b1;
          wr_data = word_data;
          if (word_cnt == LAST_WORD) begin
`ifdef FRAME_CHECKSUM_EN
            state_next = ST_TRAIL;
`else
            state_next = ST_IDLE;
            frame_done = 1'b1;
`endif
          end
        end
      end
`ifdef FRAME_CHECKSUM_EN
      // The trailer cycle doubles as the start decision for the next frame
      ST_TRAIL: begin
        wr_req     = 1'b1;
        wr_data    = checksum;
        frame_done = 1'b1;
        state_next = ST_IDLE;
        if (start_req) begin
          state_next = admit ? ST_HDR0 : ST_DROP;
          enter_drop = !admit;
        end
      end
`endif
      ST_DROP: begin
        if (sample_valid && drop_seen == DROP_LAST) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    frame_start = (state_next == ST_HDR0);
    pack_load   = sample_valid &&
                  (state == ST_HDR0 || state == ST_HDR1 || state == ST_PAYLOAD);
  end

  sample_pair_packer u_pair (
    .clk         (clk),
    .reset       (reset),
    .start       (frame_start),
    .load        (pack_load),
    .sample_data (sample_data),
    .word_valid  (word_valid),
    .word_data   (word_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      fifo_we    <= 1'b0;
      fifo_data  <= 32'd0;
      frame_seq  <= 32'd0;
      drop_count <= 16'd0;
      overflow   <= 1'b0;
      word_cnt   <= '0;
      drop_seen  <= '0;
`ifdef FRAME_CHECKSUM_EN
      checksum   <= 32'd0;
`endif
    end else begin
      state   <= state_next;
      fifo_we <= wr_req && !fifo_full;
      // A full buffer skips the word but the frame keeps its shape
      if (wr_req) begin
        if (!fifo_full) fifo_data <= wr_data;
        else            overflow  <= 1'b1;
      end
      if (frame_done) frame_seq <= frame_seq + 32'd1;
      if (enter_drop) begin
        drop_seen <= DCW'(1);
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end else if (state == ST_DROP && sample_valid) begin
        drop_seen <= drop_seen + 1'b1;
      end
      if (state == ST_HDR1)                        word_cnt <= '0;
      else if (state == ST_PAYLOAD && word_valid)  word_cnt <= word_cnt + 1'b1;
`ifdef FRAME_CHECKSUM_EN
      if (frame_start)                             checksum <= 32'd0;
      else if (state == ST_PAYLOAD && word_valid)  checksum <= checksum ^ word_data;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_adc_frame_packer: directed bench for adc_frame_packer, PAYLOAD_WORDS=4. |
// | Follows FRAME_CHECKSUM_EN when defined.                Revision: 1.0       |
// +----------------------------------------------------------------------------+
module tb_adc_frame_packer;

  localparam int PW = 4;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        fifo_we;
  logic [31:0] fifo_data;
  logic [9:0]  fifo_count;
  logic        fifo_full;
  logic [31:0] frame_seq;
  logic [15:0] drop_count;
  logic        overflow;

  int total;
  int bad;

  logic [31:0] wr_q[$];
  logic [31:0] exp_q[$];

  adc_frame_packer #(
    .PAYLOAD_WORDS (PW),
    .FIFO_DEPTH    (1024),
    .SYNC_WORD     (32'hA5A5_5A5A)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .fifo_we      (fifo_we),
    .fifo_data    (fifo_data),
    .fifo_count   (fifo_count),
    .fifo_full    (fifo_full),
    .frame_seq    (frame_seq),
    .drop_count   (drop_count),
    .overflow     (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (fifo_we === 1'b1) wr_q.push_back(fifo_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [15:0] d);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = d;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic send_frame(input int base);
    for (int i = 0; i < 2 * PW; i++) send(16'(base + i));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Expected words for one frame; payload word 'skip' is left out of the stream
  task automatic build_frame(input logic [31:0] hdr, input int base, input int skip);
    logic [31:0] w;
    logic [31:0] x;
    x = 32'd0;
    exp_q.push_back(32'hA5A5_5A5A);
    exp_q.push_back(hdr);
    for (int i = 0; i < PW; i++) begin
      w = {16'(base + 2 * i), 16'(base + 2 * i + 1)};
      x = x ^ w;
      if (i != skip) exp_q.push_back(w);
    end
`ifdef FRAME_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic compare_writes(input string tag);
    int n;
    chk({tag, ".count"}, 32'(wr_q.size()), 32'(exp_q.size()));
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s[%0d]", tag, i), wr_q[i], exp_q[i]);
    wr_q.delete();
    exp_q.delete();
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b1;
    enable       = 1'b1;
    sample_valid = 1'b0;
    sample_data  = 16'd0;
    fifo_count   = 10'd0;
    fifo_full    = 1'b0;
    idle(3);
    reset = 1'b0;

    chk("rst.fifo_we",    32'(fifo_we),    32'd0);
    chk("rst.fifo_data",  fifo_data,       32'd0);
    chk("rst.frame_seq",  frame_seq,       32'd0);
    chk("rst.drop_count", 32'(drop_count), 32'd0);
    chk("rst.overflow",   32'(overflow),   32'd0);

    // Basic frame from samples 1..8
    idle(2);
    send_frame(1);
    idle(6);
    build_frame(32'h0000_0000, 1, -1);
    compare_writes("basic");
    chk("basic.frame_seq",  frame_seq,       32'd1);
    chk("basic.overflow",   32'(overflow),   32'd0);

    // Reset mid-payload clears every output on the next cycle
    send(16'd1);
    send(16'd2);
    send(16'd3);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst.fifo_we",    32'(fifo_we),    32'd0);
    chk("midrst.fifo_data",  fifo_data,       32'd0);
    chk("midrst.frame_seq",  frame_seq,       32'd0);
    chk("midrst.drop_count", 32'(drop_count), 32'd0);
    chk("midrst.overflow",   32'(overflow),   32'd0);
    reset = 1'b0;
    wr_q.delete();
    idle(2);
    send_frame(1);
    idle(6);
    build_frame(32'h0000_0000, 1, -1);
    compare_writes("postrst");

    // No room: whole frame dropped, then next frame carries the drop count
    do_reset();
    fifo_count = 10'd1020;
    send_frame(1);
    idle(6);
    chk("drop.writes",     32'(wr_q.size()), 32'd0);
    chk("drop.drop_count", 32'(drop_count),  32'd1);
    chk("drop.frame_seq",  frame_seq,        32'd0);
    wr_q.delete();
    fifo_count = 10'd0;
    send_frame(9);
    idle(6);
    build_frame(32'h0000_0001, 9, -1);
    compare_writes("afterdrop");
    chk("afterdrop.frame_seq", frame_seq, 32'd1);

    // enable falls mid-frame: frame still completes, later samples ignored
    do_reset();
    enable = 1'b1;
    for (int i = 1; i <= 3; i++) send(16'(i));
    enable = 1'b0;
    for (int i = 4; i <= 8; i++) send(16'(i));
    idle(6);
    build_frame(32'h0000_0000, 1, -1);
    compare_writes("endis");
    send(16'd9);
    idle(8);
    chk("endis.idle_writes", 32'(wr_q.size()), 32'd0);
    chk("endis.frame_seq",   frame_seq,        32'd1);
    wr_q.delete();
    enable = 1'b1;

    // fifo_full during the 2nd payload word write
    do_reset();
    for (int i = 1; i <= 4; i++) send(16'(i));
    fifo_full = 1'b1;
    @(negedge clk);
    fifo_full = 1'b0;
    for (int i = 5; i <= 8; i++) send(16'(i));
    idle(6);
    build_frame(32'h0000_0000, 1, 1);
    compare_writes("full");
    chk("full.overflow",  32'(overflow), 32'd1);
    chk("full.frame_seq", frame_seq,     32'd1);
    idle(10);
    chk("full.sticky",    32'(overflow), 32'd1);

    // Back-to-back frames, second frame's first sample right after the last word
    do_reset();
    send_frame(1);
    send_frame(9);
    idle(6);
    build_frame(32'h0000_0000, 1, -1);
    build_frame(32'h0001_0000, 9, -1);
    compare_writes("b2b");
    chk("b2b.frame_seq",  frame_seq,       32'd2);
    chk("b2b.drop_count", 32'(drop_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
